// File: rtl/key_pio_irq.sv
// Avalon-MM input PIO: 2-FF synchroniser, optional debounce, sticky W1C edge capture, maskable level irq.
// Build option: define KEY_PIO_DEBOUNCE_EN to include the per-channel debounce counters.
module key_pio_irq #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wdata;

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_param_check
    $error("key_pio_irq: illegal parameter combination");
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[gi] != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= IDLE_LEVEL;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable[gi] = stable_q;
  end
`else
  assign stable = sync2_q;
`endif

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = stable;

    case (EDGE_TYPE)
      0:       edge_sel = stable & ~prev_q;
      1:       edge_sel = ~stable & prev_q;
      default: edge_sel = stable ^ prev_q;
    endcase

    // A new edge wins over a clear landing in the same cycle.
    clr_bits  = (write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~clr_bits) | edge_sel;

    mask_d = mask_q;
    if (write && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= {WIDTH{IDLE_LEVEL}};
      sync2_q    <= {WIDTH{IDLE_LEVEL}};
      prev_q     <= {WIDTH{IDLE_LEVEL}};
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = |(edgecap_q & mask_q);
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_key_pio_irq.sv
// Directed self-checking bench for key_pio_irq; expectations follow KEY_PIO_DEBOUNCE_EN if defined.
module tb_key_pio_irq;
  localparam int W   = 2;
  localparam int DEB = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [1:0]    address   = 2'd0;
  logic          write     = 1'b0;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_main   = '1;
  logic [W-1:0]  in_any    = '1;
  logic [W-1:0]  in_rise   = '1;
  logic [31:0]   rd_main, rd_any, rd_rise;
  logic          irq_main, irq_any, irq_rise;
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  key_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_main), .in_port(in_main), .irq(irq_main));

  key_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)) dut_any (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_any), .in_port(in_any), .irq(irq_any));

  key_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0), .IDLE_LEVEL(1'b1)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_rise), .in_port(in_rise), .irq(irq_rise));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a);
    address = a;
    write   = 1'b0;
    tick();
    $display("read  addr=%0d main=%08h any=%08h rise=%08h", a, rd_main, rd_any, rd_rise);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
    $display("write addr=%0d data=%08h", a, d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (rd_main !== 32'h0) $display("FAIL reset_readdata: got %08h expected 00000000", rd_main); else passes++;
    checks++; if (irq_main !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq_main); else passes++;
    reset = 1'b0;
    do_read(2'd0);
    checks++; if (rd_main !== 32'h3) $display("FAIL idle_data: got %08h expected 00000003", rd_main); else passes++;
    do_read(2'd3);
    checks++; if (rd_main !== 32'h0) $display("FAIL idle_edgecap: got %08h expected 00000000", rd_main); else passes++;
    checks++; if (irq_main !== 1'b0) $display("FAIL idle_irq: got %0b expected 0", irq_main); else passes++;
  endtask

  task automatic test_clean_press();
    do_write(2'd2, 32'h1);
    in_main[0] = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (irq_main !== 1'b0) $display("FAIL press_irq_early: got %0b expected 0", irq_main); else passes++;
    tick();
    checks++; if (irq_main !== 1'b1) $display("FAIL press_irq: got %0b expected 1", irq_main); else passes++;
    do_read(2'd3);
    checks++; if (rd_main !== 32'h1) $display("FAIL press_edgecap: got %08h expected 00000001", rd_main); else passes++;
    do_read(2'd0);
    checks++; if (rd_main !== 32'h2) $display("FAIL press_data: got %08h expected 00000002", rd_main); else passes++;
    do_write(2'd3, 32'h1);
    checks++; if (irq_main !== 1'b0) $display("FAIL press_clear_irq: got %0b expected 0", irq_main); else passes++;
    repeat (LAT) tick();
    do_read(2'd3);
    checks++; if (rd_main !== 32'h0) $display("FAIL press_single_pulse: got %08h expected 00000000", rd_main); else passes++;
    in_main[0] = 1'b1;
    repeat (LAT + 1) tick();
    do_read(2'd3);
    checks++; if (rd_main !== 32'h0) $display("FAIL release_not_captured: got %08h expected 00000000", rd_main); else passes++;
  endtask

`ifdef KEY_PIO_DEBOUNCE_EN
  task automatic test_bounce();
    repeat (5) begin
      in_main[1] = 1'b0;
      repeat (3) tick();
      in_main[1] = 1'b1;
      repeat (3) tick();
    end
    repeat (4) tick();
    do_read(2'd0);
    checks++; if (rd_main !== 32'h3) $display("FAIL bounce_data: got %08h expected 00000003", rd_main); else passes++;
    do_read(2'd3);
    checks++; if (rd_main !== 32'h0) $display("FAIL bounce_edgecap: got %08h expected 00000000", rd_main); else passes++;
    in_main[1] = 1'b0;
    repeat (10) tick();
    do_read(2'd3);
    checks++; if (rd_main !== 32'h2) $display("FAIL hold_edgecap: got %08h expected 00000002", rd_main); else passes++;
    in_main[1] = 1'b1;
    repeat (LAT + 1) tick();
  endtask
`else
  task automatic test_macro_off();
    in_main[0] = 1'b0;
    tick();
    in_main[0] = 1'b1;
    tick();
    checks++; if (irq_main !== 1'b0) $display("FAIL pulse_irq_early: got %0b expected 0", irq_main); else passes++;
    tick();
    checks++; if (irq_main !== 1'b1) $display("FAIL pulse_irq: got %0b expected 1", irq_main); else passes++;
    do_read(2'd3);
    checks++; if (rd_main !== 32'h1) $display("FAIL pulse_edgecap: got %08h expected 00000001", rd_main); else passes++;
    repeat (LAT + 1) tick();
  endtask
`endif

  task automatic test_mask_race();
    do_write(2'd3, 32'h3);
    do_write(2'd2, 32'h0);
    in_main[1] = 1'b0;
    repeat (LAT + 1) tick();
    checks++; if (irq_main !== 1'b0) $display("FAIL masked_irq: got %0b expected 0", irq_main); else passes++;
    do_read(2'd3);
    checks++; if (rd_main !== 32'h2) $display("FAIL masked_edgecap: got %08h expected 00000002", rd_main); else passes++;
    do_write(2'd2, 32'h3);
    checks++; if (irq_main !== 1'b1) $display("FAIL unmask_irq: got %0b expected 1", irq_main); else passes++;
    do_write(2'd3, 32'h2);
    checks++; if (irq_main !== 1'b0) $display("FAIL race_pre_clear: got %0b expected 0", irq_main); else passes++;
    in_main[1] = 1'b1;
    repeat (LAT + 1) tick();
    // Hold the clear strobe on exactly the edge that captures the new falling edge.
    in_main[1] = 1'b0;
    repeat (LAT - 1) tick();
    do_write(2'd3, 32'h2);
    checks++; if (irq_main !== 1'b1) $display("FAIL race_irq: got %0b expected 1", irq_main); else passes++;
    do_read(2'd3);
    checks++; if (rd_main !== 32'h2) $display("FAIL race_edgecap: got %08h expected 00000002", rd_main); else passes++;
    in_main[1] = 1'b1;
    repeat (LAT + 1) tick();
    do_write(2'd3, 32'h3);
  endtask

  task automatic test_edge_modes();
    in_any[0]  = 1'b0;
    in_rise[0] = 1'b0;
    repeat (LAT + 1) tick();
    do_read(2'd3);
    checks++; if (rd_any !== 32'h1) $display("FAIL any_press: got %08h expected 00000001", rd_any); else passes++;
    checks++; if (rd_rise !== 32'h0) $display("FAIL rise_press_ignored: got %08h expected 00000000", rd_rise); else passes++;
    do_write(2'd3, 32'h1);
    checks++; if (irq_any !== 1'b0) $display("FAIL any_clear: got %0b expected 0", irq_any); else passes++;
    in_any[0]  = 1'b1;
    in_rise[0] = 1'b1;
    repeat (LAT + 1) tick();
    do_read(2'd3);
    checks++; if (rd_any !== 32'h1) $display("FAIL any_release: got %08h expected 00000001", rd_any); else passes++;
    checks++; if (rd_rise !== 32'h1) $display("FAIL rise_release: got %08h expected 00000001", rd_rise); else passes++;
    checks++; if (irq_rise !== 1'b1) $display("FAIL rise_irq: got %0b expected 1", irq_rise); else passes++;
    do_write(2'd3, 32'h3);
  endtask

  task automatic test_register_map();
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd1);
    checks++; if (rd_main !== 32'h0) $display("FAIL reserved_read: got %08h expected 00000000", rd_main); else passes++;
    do_write(2'd0, 32'h0);
    do_read(2'd0);
    checks++; if (rd_main !== 32'h3) $display("FAIL data_write_ignored: got %08h expected 00000003", rd_main); else passes++;
    do_read(2'd2);
    checks++; if (rd_main !== 32'h3) $display("FAIL mask_kept: got %08h expected 00000003", rd_main); else passes++;
    do_write(2'd2, 32'hFFFF_FFFE);
    do_read(2'd2);
    checks++; if (rd_main !== 32'h2) $display("FAIL mask_width: got %08h expected 00000002", rd_main); else passes++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
`ifdef KEY_PIO_DEBOUNCE_EN
    test_bounce();
`else
    test_macro_off();
`endif
    test_mask_race();
    test_edge_modes();
    test_register_map();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
